// File: rtl/des3_arb_pkg.sv
// Shared types and helpers for the 3DES engine arbiter.
// Holds the FSM state encoding and default block/key widths.
package des3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  localparam int DES3_DATA_W = 64;
  localparam int DES3_KEY_W  = 192;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/des3_arb_if.sv
// Requester-side job/response bundle of the 3DES arbiter.
// The master modport is the requester side, slave is the arbiter.
interface des3_arb_if
  import des3_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DES3_DATA_W,
  parameter int KEY_W   = DES3_KEY_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_decrypt;
  logic [NUM_REQ*KEY_W-1:0]  req_key;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid,
    output req_decrypt,
    output req_key,
    output req_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_decrypt,
    input  req_key,
    input  req_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot picker.
// Search starts just after the last winner and wraps around.
module rr_arbiter
  import des3_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int unsigned pos;
    pos        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = 1; i <= N; i++) begin
      pos = (int'(last) + i) % N;
      if (!any && req[pos]) begin
        any             = 1'b1;
        gnt_onehot[pos] = 1'b1;
        gnt_idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/des3_arbiter.sv
// Round-robin sharing of one 3DES core between NUM_REQ requesters.
// Sequences grant, start, watchdog-guarded run and response return.
module des3_arbiter
  import des3_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int DATA_W      = DES3_DATA_W,
  parameter  int KEY_W       = DES3_KEY_W,
  parameter  int TIMEOUT_CYC = 1023,
  localparam int GW          = clog2_min1(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  des3_arb_if.slave         host,
  output logic              core_start,
  output logic              core_decrypt,
  output logic [KEY_W-1:0]  core_key,
  output logic [DATA_W-1:0] core_din,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic [CW-1:0]       wd_cnt;
  logic [NUM_REQ-1:0]  pick;
  logic [GW-1:0]       pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                rsp_hs;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req        (host.req_valid),
    .last       (last_grant),
    .gnt_onehot (pick),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // Accept is combinational so the requester sees it in the pick cycle.
  assign host.req_ready =
    (state == IDLE && !reset) ? pick : '0;

  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;

  assign rsp_hs = |(rsp_valid_q & host.rsp_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_REQ - 1);
      wd_cnt       <= '0;
      grant_id     <= '0;
      core_start   <= 1'b0;
      core_decrypt <= 1'b0;
      core_key     <= '0;
      core_din     <= '0;
      busy         <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            core_key     <= host.req_key[pick_idx*KEY_W +: KEY_W];
            core_din     <= host.req_data[pick_idx*DATA_W +: DATA_W];
            core_decrypt <= host.req_decrypt[pick_idx];
            grant_id     <= pick_idx;
            core_start   <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
        RUN: begin
          // A done on the last allowed cycle still counts as success.
          if (core_done) begin
            rsp_data_q  <= core_dout;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= ONE << grant_id;
            state       <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= ONE << grant_id;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            busy        <= 1'b0;
            last_grant  <= grant_id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ready_oh: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(host.req_ready));

  a_valid_oh: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(host.rsp_valid));

  a_start_pulse: assert property (
    @(posedge clk) disable iff (reset)
    core_start |=> !core_start);

endmodule

// File: tb/tb_des3_arbiter.sv
// Scoreboard bench for des3_arbiter with a toy core model.
// Expected grants, data, errors and timing come from a job-level model.
module tb_des3_arbiter;
  import des3_arb_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int KW = 192;
  localparam int T  = 1023;
  localparam int GW = clog2_min1(N);
  localparam int NEVER = 1 << 20;

  typedef struct {
    logic [KW-1:0] key;
    logic [DW-1:0] data;
    logic          dec;
    int            lat;
    bit            fixed;
    logic [DW-1:0] fdout;
  } job_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          err;
    int            when;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_start, core_decrypt, core_done, busy;
  logic [KW-1:0] core_key;
  logic [DW-1:0] core_din, core_dout;
  logic [GW-1:0] grant_id;

  des3_arb_if #(.NUM_REQ(N), .DATA_W(DW), .KEY_W(KW)) bus ();

  des3_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .KEY_W(KW), .TIMEOUT_CYC(T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (bus),
    .core_start   (core_start),
    .core_decrypt (core_decrypt),
    .core_key     (core_key),
    .core_din     (core_din),
    .core_done    (core_done),
    .core_dout    (core_dout),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  job_t jq[N][$];
  exp_t scb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit m_free = 1'b1, start_exp = 1'b0, chk_zero = 1'b0, seen = 1'b0;
  int m_last = N - 1;
  int core_lat = 1, done_at = -1, bp_left = 0;
  bit core_fixed = 1'b0, rnd_ready = 1'b0;
  logic [DW-1:0] core_fval = '0, done_val = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] toy(
    input logic [KW-1:0] k, input logic [DW-1:0] d, input logic dec);
    logic [63:0] k2;
    k2 = k[127:64];
    return d ^ k[63:0] ^ {k2[31:0], k2[63:32]} ^ k[191:128] ^ {64{dec}};
  endfunction

  function automatic job_t rjob(input int lat);
    job_t j;
    j.key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    j.data  = {$urandom, $urandom};
    j.dec   = 1'($urandom);
    j.lat   = lat;
    j.fixed = 1'b0;
    j.fdout = '0;
    return j;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Job-level model: grant rule, response contents and response cycle.
  task automatic monitor_step();
    logic [N-1:0] exp_rdy;
    int g;
    job_t j;
    exp_t e;
    if (reset) begin
      scb.delete();
      m_free = 1'b1; m_last = N - 1;
      start_exp = 1'b0; seen = 1'b0; chk_zero = 1'b1;
      return;
    end
    if (chk_zero) begin
      chk("reset_outputs", 64'(|{bus.req_ready, bus.rsp_valid, bus.rsp_data,
          bus.rsp_err, core_start, core_decrypt, core_key, core_din,
          busy, grant_id}), 64'd0);
      chk_zero = 1'b0;
    end
    chk("busy", 64'(busy), 64'(!m_free));
    chk("core_start", 64'(core_start), 64'(start_exp));
    start_exp = 1'b0;
    exp_rdy = '0;
    if (m_free && |bus.req_valid) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (g < 0 && bus.req_valid[p]) g = p;
      end
      exp_rdy[g] = 1'b1;
      j = jq[g][0];
      e.id   = g;
      e.err  = (j.lat > T);
      e.data = e.err ? '0 : (j.fixed ? j.fdout : toy(j.key, j.data, j.dec));
      e.when = cyc + 2 + ((j.lat < T) ? j.lat : T);
      scb.push_back(e);
      m_free = 1'b0; start_exp = 1'b1;
      core_lat = j.lat; core_fixed = j.fixed; core_fval = j.fdout;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (|bus.rsp_valid) begin
      if (scb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid %b with no job outstanding (cycle %0d)",
                 bus.rsp_valid, cyc);
      end else begin
        e = scb[0];
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(1) << e.id);
        chk("grant_id", 64'(grant_id), 64'(e.id));
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        if (!seen) begin
          chk("rsp_cycle", 64'(cyc), 64'(e.when));
          seen = 1'b1;
        end
        if (bus.rsp_ready[e.id]) begin
          void'(scb.pop_front());
          seen = 1'b0; m_free = 1'b1; m_last = e.id;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  // Toy 3DES core: answers L cycles after the start pulse.
  initial forever begin
    @(negedge clk);
    if (reset) done_at = -1;
    else if (core_start) begin
      done_at  = cyc + core_lat;
      done_val = core_fixed ? core_fval : toy(core_key, core_din, core_decrypt);
    end
  end

  initial begin
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(posedge clk); #1;
      core_done = (cyc == done_at);
      core_dout = core_done ? done_val : {$urandom, $urandom};
    end
  end

  // Requesters hold a job until accepted; response side may backpressure.
  initial begin
    logic [N-1:0] acc, v, d;
    logic [N*KW-1:0] k;
    logic [N*DW-1:0] dt;
    bit vld;
    bus.req_valid = '0; bus.req_decrypt = '0;
    bus.req_key = '0; bus.req_data = '0; bus.rsp_ready = '1;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      vld = |bus.rsp_valid;
      @(posedge clk); #1;
      v = '0; d = '0; k = '0; dt = '0;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && jq[i].size() > 0) void'(jq[i].pop_front());
        if (jq[i].size() > 0) begin
          v[i] = 1'b1;
          d[i] = jq[i][0].dec;
          k[i*KW +: KW]  = jq[i][0].key;
          dt[i*DW +: DW] = jq[i][0].data;
        end
      end
      bus.req_valid = v; bus.req_decrypt = d;
      bus.req_key = k; bus.req_data = dt;
      if (bp_left > 0) begin
        bus.rsp_ready = '0;
        if (vld) bp_left--;
      end else begin
        bus.rsp_ready = rnd_ready ? N'($urandom) : '1;
      end
    end
  end

  task automatic wait_idle(input int max_cyc, input string nm);
    int n;
    n = 0;
    while ((jq[0].size() > 0 || jq[1].size() > 0 || scb.size() > 0 || !m_free)
           && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, limit %0d", nm, n, max_cyc);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    job_t j;
    int n;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    j = rjob(48);
    j.key   = 192'h0123456789ABCDEF_23456789ABCDEF01_456789ABCDEF0123;
    j.data  = 64'h4E6F772069732074;
    j.dec   = 1'b0;
    j.fixed = 1'b1;
    j.fdout = 64'hDEADBEEFCAFEF00D;
    jq[0].push_back(j);
    wait_idle(500, "single");

    for (int r = 0; r < 2; r++) begin
      jq[0].push_back(rjob($urandom_range(1, 60)));
      jq[1].push_back(rjob($urandom_range(1, 60)));
    end
    wait_idle(1000, "round_robin");

    jq[1].push_back(rjob(NEVER));
    wait_idle(3000, "watchdog_never");
    jq[0].push_back(rjob(T + 4));
    wait_idle(3000, "watchdog_late");
    repeat (10) @(posedge clk);
    #2;

    jq[1].push_back(rjob(T));
    jq[0].push_back(rjob(T + 1));
    jq[1].push_back(rjob(T - 1));
    wait_idle(8000, "collision");

    bp_left = 10;
    jq[0].push_back(rjob($urandom_range(5, 20)));
    jq[1].push_back(rjob($urandom_range(5, 20)));
    wait_idle(1000, "backpressure");

    jq[0].push_back(rjob(20));
    wait_idle(500, "pre_reset");
    jq[1].push_back(rjob(500));
    n = 0;
    while (!busy && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("busy_before_reset", 64'(busy), 64'd1);
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    jq[1].push_back(rjob($urandom_range(1, 30)));
    jq[0].push_back(rjob($urandom_range(1, 30)));
    wait_idle(500, "after_reset");

    rnd_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      jq[$urandom_range(0, N - 1)].push_back(rjob($urandom_range(1, 100)));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #2;
    end
    wait_idle(20000, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
